// File: rtl/align_shifter.sv
// Pre-add exponent alignment: picks the larger-exponent operand and right-shifts the other
// mantissa by the exponent difference, at most STEP bits per cycle, keeping guard/round/sticky.
module align_shifter #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 24,
    parameter int unsigned STEP  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [EXP_W-1:0] exp_a,
    input  logic [MAN_W-1:0] man_a,
    input  logic [EXP_W-1:0] exp_b,
    input  logic [MAN_W-1:0] man_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EXP_W-1:0] exp_out,
    output logic [MAN_W-1:0] man_big,
    output logic [MAN_W+2:0] man_small,
    output logic             swapped
);

    localparam int unsigned SM_W  = MAN_W + 3;
    localparam int unsigned REM_W = $clog2(SM_W + 1);

    typedef enum logic [1:0] {StIdle, StShift, StHold} state_e;

    state_e           state_q, state_d;
    logic [EXP_W-1:0] exp_out_q;
    logic [MAN_W-1:0] man_big_q;
    logic [SM_W-1:0]  man_small_q;
    logic             swapped_q;
    logic [REM_W-1:0] rem_q;

    logic             accept;
    logic             a_big;
    logic [EXP_W-1:0] exp_diff;
    logic [REM_W-1:0] rem_init;
    logic [REM_W-1:0] step_k;
    logic [REM_W-1:0] rem_after;
    logic             sticky_out;
    logic [SM_W-1:0]  sm_shifted;

    // Operand selection and clamped shift distance for the accept cycle.
    always_comb begin
        a_big    = (exp_a >= exp_b);
        exp_diff = a_big ? (exp_a - exp_b) : (exp_b - exp_a);
        if (32'(exp_diff) >= SM_W) begin
            rem_init = REM_W'(SM_W);
        end else begin
            rem_init = REM_W'(exp_diff);
        end
    end

    // One shift step: bits falling off the bottom are folded into the sticky bit.
    always_comb begin
        step_k     = (rem_q < REM_W'(STEP)) ? rem_q : REM_W'(STEP);
        rem_after  = rem_q - step_k;
        sticky_out = 1'b0;
        for (int unsigned i = 0; i < STEP; i++) begin
            if (REM_W'(i) < step_k) begin
                sticky_out = sticky_out | man_small_q[i];
            end
        end
        sm_shifted    = man_small_q >> step_k;
        sm_shifted[0] = sm_shifted[0] | sticky_out;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = (rem_init == '0) ? StHold : StShift;
                end
            end
            StShift: begin
                if (rem_after == '0) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StHold);
    end

    assign accept = (state_q == StIdle) && in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_out_q   <= '0;
            man_big_q   <= '0;
            man_small_q <= '0;
            swapped_q   <= 1'b0;
            rem_q       <= '0;
        end else if (accept) begin
            exp_out_q   <= a_big ? exp_a : exp_b;
            man_big_q   <= a_big ? man_a : man_b;
            man_small_q <= a_big ? {man_b, 3'b000} : {man_a, 3'b000};
            swapped_q   <= ~a_big;
            rem_q       <= rem_init;
        end else if (state_q == StShift) begin
            man_small_q <= sm_shifted;
            rem_q       <= rem_after;
        end
    end

    assign exp_out   = exp_out_q;
    assign man_big   = man_big_q;
    assign man_small = man_small_q;
    assign swapped   = swapped_q;

endmodule

// File: tb/tb_align_shifter.sv
// Scoreboard bench for align_shifter: directed cases, backpressure, reset aborts and a
// randomized stream checked against a whole-shift reference model.
module tb_align_shifter;

    localparam int STEP = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  exp_a = '0;
    logic [23:0] man_a = '0;
    logic [7:0]  exp_b = '0;
    logic [23:0] man_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  exp_out;
    logic [23:0] man_big;
    logic [26:0] man_small;
    logic        swapped;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0]  e;
        logic [23:0] big;
        logic [26:0] sm;
        logic        sw;
        int          lat;
    } exp_t;

    exp_t exp_q[$];

    align_shifter #(.EXP_W(8), .MAN_W(24), .STEP(STEP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .exp_a     (exp_a),
        .man_a     (man_a),
        .exp_b     (exp_b),
        .man_b     (man_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .exp_out   (exp_out),
        .man_big   (man_big),
        .man_small (man_small),
        .swapped   (swapped)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [7:0] e, input logic [23:0] big,
                                input logic [26:0] sm, input logic sw, input int lat);
        exp_t r;
        r.e = e; r.big = big; r.sm = sm; r.sw = sw; r.lat = lat;
        return r;
    endfunction

    // Reference: one full shift, sticky = OR of every original bit below the shift amount.
    function automatic exp_t model(input logic [7:0] ea, input logic [23:0] ma,
                                   input logic [7:0] eb, input logic [23:0] mb);
        exp_t        r;
        logic [26:0] full;
        logic [7:0]  d;
        int          rem;
        logic        st;
        if (ea >= eb) begin
            r.e = ea; r.big = ma; r.sw = 1'b0; full = {mb, 3'b000}; d = ea - eb;
        end else begin
            r.e = eb; r.big = mb; r.sw = 1'b1; full = {ma, 3'b000}; d = eb - ea;
        end
        rem = (d > 8'd27) ? 27 : int'(d);
        st = 1'b0;
        for (int i = 0; i < rem; i++) st = st | full[i];
        r.sm = full >> rem;
        r.sm[0] = r.sm[0] | st;
        r.lat = (rem + STEP - 1) / STEP + 1;
        return r;
    endfunction

    task automatic drive(input logic [7:0] ea, input logic [23:0] ma,
                         input logic [7:0] eb, input logic [23:0] mb);
        int n = 0;
        @(negedge clk);
        exp_a = ea; man_a = ma; exp_b = eb; man_b = mb; in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++; failures++;
            $display("FAIL accept_timeout in_ready=%b required=1", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 40);
        if (!out_valid) lat = -1;
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic run_one(input logic [7:0] ea, input logic [23:0] ma, input logic [7:0] eb,
                           input logic [23:0] mb, output exp_t e, output int lat,
                           output logic [59:0] act);
        drive(ea, ma, eb, mb);
        wait_valid(lat);
        act = {exp_out, man_big, man_small, swapped};
        e = exp_q.pop_front();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b1; exp_a = 8'h85; man_a = 24'hC00000; exp_b = 8'h83; man_b = 24'h800000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({out_valid, in_ready, exp_out, man_big, man_small, swapped} !== {2'b01, 60'h0}) begin
            failures++;
            $display("FAIL reset_state got v=%b r=%b e=%h b=%h s=%h sw=%b required v=0 r=1 rest 0",
                     out_valid, in_ready, exp_out, man_big, man_small, swapped);
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release got v=%b r=%b required v=0 r=1", out_valid, in_ready);
        end
    endtask

    task automatic test_small_diff();
        exp_t e; int lat; logic [59:0] act;
        exp_q.push_back(mk(8'h85, 24'hC00000, 27'h1000000, 1'b0, 2));
        run_one(8'h85, 24'hC00000, 8'h83, 24'h800000, e, lat, act);
        checks++;
        if (lat !== e.lat) begin
            failures++; $display("FAIL small_latency got %0d required %0d", lat, e.lat);
        end
        checks++;
        if (act !== {e.e, e.big, e.sm, e.sw}) begin
            failures++; $display("FAIL small_data got %h required %h", act, {e.e, e.big, e.sm, e.sw});
        end
        release_out();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL small_release got v=%b r=%b required v=0 r=1", out_valid, in_ready);
        end
    endtask

    task automatic test_swap_round();
        exp_t e; int lat; logic [59:0] act;
        exp_q.push_back(mk(8'h81, 24'hFFFFFF, 27'h1000002, 1'b1, 2));
        run_one(8'h7F, 24'h800001, 8'h81, 24'hFFFFFF, e, lat, act);
        checks++;
        if (lat !== e.lat) begin
            failures++; $display("FAIL swap_latency got %0d required %0d", lat, e.lat);
        end
        checks++;
        if (act !== {e.e, e.big, e.sm, e.sw}) begin
            failures++; $display("FAIL swap_data got %h required %h", act, {e.e, e.big, e.sm, e.sw});
        end
        release_out();
    endtask

    task automatic test_clamp();
        exp_t e; int lat; logic [59:0] act;
        exp_q.push_back(mk(8'hFE, 24'h800000, 27'h0000001, 1'b0, 8));
        run_one(8'hFE, 24'h800000, 8'h01, 24'h000001, e, lat, act);
        checks++;
        if (lat !== e.lat) begin
            failures++; $display("FAIL clamp_latency got %0d required %0d", lat, e.lat);
        end
        checks++;
        if (act !== {e.e, e.big, e.sm, e.sw}) begin
            failures++; $display("FAIL clamp_data got %h required %h", act, {e.e, e.big, e.sm, e.sw});
        end
        release_out();
    endtask

    task automatic test_equal_exp();
        exp_t e; int lat; logic [59:0] act;
        exp_q.push_back(mk(8'h90, 24'h800000, 27'h55E6F78, 1'b0, 1));
        run_one(8'h90, 24'h800000, 8'h90, 24'hABCDEF, e, lat, act);
        checks++;
        if (lat !== e.lat) begin
            failures++; $display("FAIL equal_latency got %0d required %0d", lat, e.lat);
        end
        checks++;
        if (act !== {e.e, e.big, e.sm, e.sw}) begin
            failures++; $display("FAIL equal_data got %h required %h", act, {e.e, e.big, e.sm, e.sw});
        end
        release_out();
    endtask

    task automatic test_backpressure();
        exp_t e; int lat; logic [59:0] act;
        logic [59:0] want;
        exp_q.push_back(mk(8'h85, 24'hC00000, 27'h1000000, 1'b0, 2));
        run_one(8'h85, 24'hC00000, 8'h83, 24'h800000, e, lat, act);
        want = {e.e, e.big, e.sm, e.sw};
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            checks++;
            if ({exp_out, man_big, man_small, swapped} !== want || in_ready !== 1'b0
                || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold cycle %0d got %h v=%b r=%b required %h v=1 r=0", c,
                         {exp_out, man_big, man_small, swapped}, out_valid, in_ready, want);
            end
            if (c < 5) begin
                in_valid = 1'b1;
                exp_a = 8'($urandom); man_a = 24'($urandom);
                exp_b = 8'($urandom); man_b = 24'($urandom);
            end else begin
                in_valid = 1'b0;
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || exp_out !== want[59:52]) begin
            failures++;
            $display("FAIL bp_release got r=%b v=%b e=%h required r=1 v=0 e=%h",
                     in_ready, out_valid, exp_out, want[59:52]);
        end
    endtask

    task automatic test_reset_mid_shift();
        exp_t e; int lat; logic [59:0] act;
        drive(8'hFE, 24'h800000, 8'h01, 24'h000001);
        @(posedge clk);
        @(posedge clk);
        #2;
        checks++;
        if (exp_out !== 8'hFE || out_valid !== 1'b0) begin
            failures++; $display("FAIL mid_shift_state got e=%h v=%b required e=fe v=0", exp_out, out_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, exp_out, man_big, man_small, swapped} !== {2'b01, 60'h0}) begin
            failures++;
            $display("FAIL async_reset got v=%b r=%b e=%h b=%h s=%h sw=%b required v=0 r=1 rest 0",
                     out_valid, in_ready, exp_out, man_big, man_small, swapped);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(mk(8'h90, 24'h800000, 27'h55E6F78, 1'b0, 1));
        run_one(8'h90, 24'h800000, 8'h90, 24'hABCDEF, e, lat, act);
        checks++;
        if (lat !== e.lat || act !== {e.e, e.big, e.sm, e.sw}) begin
            failures++;
            $display("FAIL post_reset_txn got lat=%0d %h required lat=%0d %h", lat, act, e.lat,
                     {e.e, e.big, e.sm, e.sw});
        end
        release_out();
    endtask

    task automatic test_back_to_back();
        exp_t e; int lat; logic [59:0] act;
        logic [7:0] ea, eb;
        logic [23:0] ma, mb;
        for (int t = 0; t < 30; t++) begin
            ea = 8'($urandom);
            eb = (t % 5 == 0) ? 8'($urandom) : 8'(ea + 8'($urandom_range(0, 30)) - 8'd15);
            ma = 24'($urandom) | 24'h800000;
            mb = (t % 7 == 0) ? 24'($urandom_range(0, 15)) : 24'($urandom);
            exp_q.push_back(model(ea, ma, eb, mb));
            run_one(ea, ma, eb, mb, e, lat, act);
            checks++;
            if (lat !== e.lat || act !== {e.e, e.big, e.sm, e.sw}) begin
                failures++;
                $display("FAIL b2b_%0d got lat=%0d %h required lat=%0d %h", t, lat, act, e.lat,
                         {e.e, e.big, e.sm, e.sw});
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            release_out();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_small_diff();
        test_swap_round();
        test_clamp();
        test_equal_exp();
        test_backpressure();
        test_reset_mid_shift();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
